// File: rtl/id_ex_stage_fwd_if.sv
// ID/EX pipeline register bundle: the decode stage drives it (master), the EX stage consumes it (slave).
interface id_ex_stage_fwd_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              valid_o;
    logic [31:0]       ins_o;
    logic [XLEN-1:0]   ins_addr_o;
    logic [XLEN-1:0]   reg1_rd_data_o;
    logic [XLEN-1:0]   reg2_rd_data_o;
    logic [REG_AW-1:0] reg_wr_addr_o;
    logic [XLEN-1:0]   imm_o;
    logic              mem_rd_req_o;
    logic [XLEN-1:0]   mem_rd_addr_o;

    modport master (
        output valid_o, ins_o, ins_addr_o, reg1_rd_data_o, reg2_rd_data_o,
               reg_wr_addr_o, imm_o, mem_rd_req_o, mem_rd_addr_o
    );

    modport slave (
        input valid_o, ins_o, ins_addr_o, reg1_rd_data_o, reg2_rd_data_o,
              reg_wr_addr_o, imm_o, mem_rd_req_o, mem_rd_addr_o
    );
endinterface

// File: rtl/id_ex_stage_fwd.sv
// Decode stage with operand forwarding, load-use hazard handling and the ID/EX pipeline register.
// Define ID_FWD_EN for EX/MEM forwarding with a one-cycle load-use bubble; otherwise it stalls on any pending write.
module id_ex_stage_fwd #(
    parameter int          XLEN    = 32,
    parameter int          REG_AW  = 5,
    parameter int          HOLD_W  = 3,
    parameter int          HOLD_ID = 2,
    parameter logic [31:0] NOP_INS = 32'h00000013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [HOLD_W-1:0]  hold_flag_i,
    input  logic               flush_i,
    input  logic               ins_valid_i,
    input  logic [31:0]        ins_i,
    input  logic [XLEN-1:0]    ins_addr_i,
    output logic [REG_AW-1:0]  reg1_rd_addr_o,
    output logic [REG_AW-1:0]  reg2_rd_addr_o,
    input  logic [XLEN-1:0]    reg1_rd_data_i,
    input  logic [XLEN-1:0]    reg2_rd_data_i,
    input  logic               ex_wr_en_i,
    input  logic [REG_AW-1:0]  ex_wr_addr_i,
    input  logic [XLEN-1:0]    ex_wr_data_i,
    input  logic               ex_is_load_i,
    input  logic               mem_wr_en_i,
    input  logic [REG_AW-1:0]  mem_wr_addr_i,
    input  logic [XLEN-1:0]    mem_wr_data_i,
    output logic               stall_req_o,
    id_ex_stage_fwd_if.master  id_ex
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [HOLD_W-1:0] HOLD_LVL = HOLD_W'(HOLD_ID);

    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic        is_load;
    logic        no_rs;
    logic [XLEN-1:0] imm;

    logic signed [11:0] imm_i_raw;
    logic signed [11:0] imm_s_raw;
    logic signed [12:0] imm_b_raw;
    logic signed [31:0] imm_u_raw;
    logic signed [20:0] imm_j_raw;

    assign imm_i_raw = ins_i[31:20];
    assign imm_s_raw = {ins_i[31:25], ins_i[11:7]};
    assign imm_b_raw = {ins_i[31], ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
    assign imm_u_raw = {ins_i[31:12], 12'h000};
    assign imm_j_raw = {ins_i[31], ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};

    // Source usage here drives hazard detection; unused read ports only go to 0 for U/J formats.
    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        no_rs     = 1'b0;
        imm       = '0;
        case (ins_i[6:0])
            OPC_LUI, OPC_AUIPC: begin
                writes_rd = 1'b1;
                no_rs     = 1'b1;
                imm       = XLEN'(imm_u_raw);
            end
            OPC_JAL: begin
                writes_rd = 1'b1;
                no_rs     = 1'b1;
                imm       = XLEN'(imm_j_raw);
            end
            OPC_JALR, OPC_IMM: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                imm       = XLEN'(imm_i_raw);
            end
            OPC_LOAD: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                is_load   = 1'b1;
                imm       = XLEN'(imm_i_raw);
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm      = XLEN'(imm_b_raw);
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm      = XLEN'(imm_s_raw);
            end
            OPC_OP: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

    logic [REG_AW-1:0] rd_addr;

    assign reg1_rd_addr_o = no_rs ? '0 : REG_AW'(ins_i[19:15]);
    assign reg2_rd_addr_o = no_rs ? '0 : REG_AW'(ins_i[24:20]);
    assign rd_addr        = writes_rd ? REG_AW'(ins_i[11:7]) : '0;

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            hazard;

`ifdef ID_FWD_EN
    typedef enum logic {RUN, LU_BUBBLE} lu_state_t;
    lu_state_t state;

    // A load in EX has no data yet, so it is skipped here and caught as a load-use hazard instead.
    function automatic logic [XLEN-1:0] fwd_operand(
        input logic [REG_AW-1:0] addr,
        input logic [XLEN-1:0]   rf_data,
        input logic              ex_en,
        input logic              ex_load,
        input logic [REG_AW-1:0] ex_addr,
        input logic [XLEN-1:0]   ex_data,
        input logic              mem_en,
        input logic [REG_AW-1:0] mem_addr,
        input logic [XLEN-1:0]   mem_data
    );
        if (addr == '0)
            return '0;
        if (ex_en && !ex_load && ex_addr == addr)
            return ex_data;
        if (mem_en && mem_addr == addr)
            return mem_data;
        return rf_data;
    endfunction

    logic load_hit;

    assign op1 = fwd_operand(reg1_rd_addr_o, reg1_rd_data_i, ex_wr_en_i, ex_is_load_i,
                             ex_wr_addr_i, ex_wr_data_i, mem_wr_en_i, mem_wr_addr_i, mem_wr_data_i);
    assign op2 = fwd_operand(reg2_rd_addr_o, reg2_rd_data_i, ex_wr_en_i, ex_is_load_i,
                             ex_wr_addr_i, ex_wr_data_i, mem_wr_en_i, mem_wr_addr_i, mem_wr_data_i);

    assign load_hit = ex_wr_en_i && ex_is_load_i && (ex_wr_addr_i != '0) &&
                      ((uses_rs1 && ex_wr_addr_i == reg1_rd_addr_o) ||
                       (uses_rs2 && ex_wr_addr_i == reg2_rd_addr_o));
    assign hazard   = ins_valid_i && load_hit && (state == RUN);
`else
    function automatic logic rs_pending(
        input logic [REG_AW-1:0] addr,
        input logic              ex_en,
        input logic [REG_AW-1:0] ex_addr,
        input logic              mem_en,
        input logic [REG_AW-1:0] mem_addr
    );
        return (addr != '0) && ((ex_en && ex_addr == addr) || (mem_en && mem_addr == addr));
    endfunction

    logic unused_fwd_inputs;

    assign op1    = (reg1_rd_addr_o == '0) ? '0 : reg1_rd_data_i;
    assign op2    = (reg2_rd_addr_o == '0) ? '0 : reg2_rd_data_i;
    assign hazard = ins_valid_i &&
                    ((uses_rs1 && rs_pending(reg1_rd_addr_o, ex_wr_en_i, ex_wr_addr_i,
                                             mem_wr_en_i, mem_wr_addr_i)) ||
                     (uses_rs2 && rs_pending(reg2_rd_addr_o, ex_wr_en_i, ex_wr_addr_i,
                                             mem_wr_en_i, mem_wr_addr_i)));
    assign unused_fwd_inputs = ^{ex_is_load_i, ex_wr_data_i, mem_wr_data_i};
`endif

    logic            hold_active;
    logic            take_bubble;
    logic [XLEN-1:0] load_addr;

    assign stall_req_o = hazard;
    assign hold_active = hold_flag_i >= HOLD_LVL;
    assign take_bubble = flush_i || hazard || !ins_valid_i;
    assign load_addr   = op1 + imm;

    // Flush outranks hold, so a killed instruction never stays frozen in ID/EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef ID_FWD_EN
            state <= RUN;
`endif
            id_ex.valid_o        <= 1'b0;
            id_ex.ins_o          <= NOP_INS;
            id_ex.ins_addr_o     <= '0;
            id_ex.reg1_rd_data_o <= '0;
            id_ex.reg2_rd_data_o <= '0;
            id_ex.reg_wr_addr_o  <= '0;
            id_ex.imm_o          <= '0;
            id_ex.mem_rd_req_o   <= 1'b0;
            id_ex.mem_rd_addr_o  <= '0;
        end else if (flush_i || !hold_active) begin
`ifdef ID_FWD_EN
            state <= (!flush_i && hazard) ? LU_BUBBLE : RUN;
`endif
            id_ex.valid_o        <= !take_bubble;
            id_ex.ins_o          <= take_bubble ? NOP_INS : ins_i;
            id_ex.ins_addr_o     <= take_bubble ? '0 : ins_addr_i;
            id_ex.reg1_rd_data_o <= take_bubble ? '0 : op1;
            id_ex.reg2_rd_data_o <= take_bubble ? '0 : op2;
            id_ex.reg_wr_addr_o  <= take_bubble ? '0 : rd_addr;
            id_ex.imm_o          <= take_bubble ? '0 : imm;
            id_ex.mem_rd_req_o   <= !take_bubble && is_load;
            id_ex.mem_rd_addr_o  <= (take_bubble || !is_load) ? '0 : load_addr;
        end
    end

endmodule

// File: doc/id_ex_stage_fwd.md
Name: id_ex_stage_fwd

Overview:
Parametrised successor to the decode unit. It decodes the fetched instruction, selects each source operand from the register file or from forwarded EX/MEM write-back data, and detects load-use hazards. Decoded fields are registered into the ID/EX pipeline register with hold, flush and bubble control. The block sits between the IF unit / RF unit and the EX unit, and issues the early memory-read request for loads.

Parameters:
XLEN, 32, datapath width for registers, addresses, immediates and operands
REG_AW, 5, register-file address width
HOLD_W, 3, width of hold_flag_i
HOLD_ID, 2, hold_flag_i value at or above which the ID/EX register freezes
NOP_INS, 32'h00000013, instruction emitted on reset, flush or bubble (addi x0,x0,0)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
hold_flag_i  in  HOLD_W  pipeline hold level from the control unit
flush_i  in  1  kill the instruction entering EX (taken jump/branch)
ins_valid_i  in  1  ins_i/ins_addr_i are valid this cycle
ins_i  in  32  instruction from IF
ins_addr_i  in  XLEN  instruction address from IF
reg1_rd_addr_o  out  REG_AW  rs1 address to RF (combinational)
reg2_rd_addr_o  out  REG_AW  rs2 address to RF (combinational)
reg1_rd_data_i  in  XLEN  RF read data for rs1
reg2_rd_data_i  in  XLEN  RF read data for rs2
ex_wr_en_i  in  1  EX-stage instruction writes rd
ex_wr_addr_i  in  REG_AW  EX-stage rd
ex_wr_data_i  in  XLEN  EX-stage result
ex_is_load_i  in  1  EX-stage instruction is a load (result not yet available)
mem_wr_en_i  in  1  MEM-stage instruction writes rd
mem_wr_addr_i  in  REG_AW  MEM-stage rd
mem_wr_data_i  in  XLEN  MEM-stage result
stall_req_o  out  1  request that IF/ID hold (combinational)
valid_o  out  1  ID/EX register holds a real instruction
ins_o  out  32  registered instruction
ins_addr_o  out  XLEN  registered instruction address
reg1_rd_data_o  out  XLEN  registered rs1 operand
reg2_rd_data_o  out  XLEN  registered rs2 operand
reg_wr_addr_o  out  REG_AW  registered rd (0 if the instruction does not write)
imm_o  out  XLEN  registered sign-extended immediate
mem_rd_req_o  out  1  registered load request
mem_rd_addr_o  out  XLEN  registered load address

Behaviour:
- Decode (combinational):
  - rs1 = ins_i[19:15], rs2 = ins_i[24:20], rd = ins_i[11:7].
  - Immediate formats: I, S, B, U, J, selected by opcode, sign-extended to XLEN.
  - Opcodes that use no rs1/rs2 (LUI, AUIPC, JAL) drive the unused read address to 0.
- Forwarding, per operand:
  - Priority: EX match (ex_wr_en_i, address equal, not ex_is_load_i), then MEM match, then RF data.
  - Address 0 is never forwarded; the operand reads 0.
- Load-use hazard: ins_valid_i & ex_wr_en_i & ex_is_load_i & ex_wr_addr_i != 0 & ex_wr_addr_i equals a used rs.
- Load-use FSM:
  - States: RUN, LU_BUBBLE.
  - RUN → LU_BUBBLE on hazard (unless hold or flush). stall_req_o=1 in that cycle, and a bubble is written into ID/EX.
  - LU_BUBBLE → RUN unconditionally next cycle. stall_req_o=0; the load result is now in MEM and is forwarded.
  - flush_i forces RUN.
- ID/EX register update, priority from highest to lowest:
  1. rst: ins_o=NOP_INS; all other outputs 0; valid_o=0; FSM=RUN.
  2. flush_i: bubble (NOP_INS, valid_o=0, reg_wr_addr_o=0, mem_rd_req_o=0, other fields 0).
  3. hold_flag_i >= HOLD_ID: all registers keep their value; FSM keeps its state.
  4. Load-use hazard, or ins_valid_i=0: bubble.
  5. Otherwise: capture decoded fields; valid_o=1.
- Load handling: mem_rd_req_o=1 when a load opcode is captured. mem_rd_addr_o = forwarded rs1 + imm, mod 2^XLEN (wrap, no carry out).
- Latency: one clk from ins_i to ID/EX outputs.
- Reset asserted mid-instruction clears the register immediately, asynchronously.

Optional Feature:
ID_FWD_EN
- Defined: forwarding and the one-cycle load-use FSM as above.
- Undefined:
  - Operands come from the RF only.
  - stall_req_o=1 and a bubble is inserted in every cycle where any used nonzero rs matches a write-enabled EX or MEM rd.
  - The stall persists until no match remains. The FSM is absent.

Test Plan:
- Reset: assert rst with ins_i=32'h00500093 → ins_o=32'h00000013, valid_o=0, all other outputs 0. After release, next edge → imm_o=5, reg_wr_addr_o=1, valid_o=1.
- EX forward: addi x2,x1,0 with reg1_rd_data_i=7, EX writes x1=0x10, MEM writes x1=0x20 → reg1_rd_data_o=0x10.
- x0 guard: EX writes x0=0xFF, instruction reads x0 → operand 0, no stall.
- Load-use: EX is lw x5 (ex_is_load_i=1), ID holds add x6,x5,x5 → stall_req_o=1 for 1 cycle, bubble in ID/EX. Next cycle MEM x5=0x1234 → both operands 0x1234.
- Hold vs flush: hold_flag_i=3 for 2 cycles → outputs frozen. hold_flag_i=3 with flush_i=1 → bubble, valid_o=0.
- Load address wrap: lw with rs1=0xFFFFFFFC, imm=8 → mem_rd_req_o=1, mem_rd_addr_o=0x00000004.
